// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Handshake bundle between fetch, the fetch queue and decode.
//   Ports (all signals, grouped by side):
//     flush_i     redirect: discard every queued entry
//     if_valid_i  fetch presents a (pc, inst) pair
//     if_pc_i     address of the fetched instruction
//     if_inst_i   fetched instruction word
//     if_ready_o  queue can take a push this cycle
//     id_ready_i  decode consumes the head this cycle
//     id_valid_o  head entry is valid
//     id_pc_o     head address, zero when empty
//     id_inst_o   head instruction, zero when empty
//     count_o     current occupancy, 0..DEPTH
//   Modports:
//     master  fetch/decode/redirect side (drives the *_i signals)
//     slave   the queue itself (drives the *_o signals)
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  flush_i;
  logic                  if_valid_i;
  logic [ADDR_WIDTH-1:0] if_pc_i;
  logic [INST_WIDTH-1:0] if_inst_i;
  logic                  if_ready_o;
  logic                  id_ready_i;
  logic                  id_valid_o;
  logic [ADDR_WIDTH-1:0] id_pc_o;
  logic [INST_WIDTH-1:0] id_inst_o;
  logic [CNT_W-1:0]      count_o;

  modport master (
    output flush_i,
    output if_valid_i,
    output if_pc_i,
    output if_inst_i,
    input  if_ready_o,
    output id_ready_i,
    input  id_valid_o,
    input  id_pc_o,
    input  id_inst_o,
    input  count_o
  );

  modport slave (
    input  flush_i,
    input  if_valid_i,
    input  if_pc_i,
    input  if_inst_i,
    output if_ready_o,
    input  id_ready_i,
    output id_valid_o,
    output id_pc_o,
    output id_inst_o,
    output count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   DEPTH-entry circular instruction queue between fetch and decode. Lets
//   fetch run ahead while decode stalls, presents the oldest (pc, inst) pair
//   to decode, and shows an all-zero bubble when empty. A flush empties the
//   queue on the next edge for branch/jump redirects.
//   Ports:
//     clk  clock, all state updates on the rising edge
//     rst  synchronous active-high reset (highest priority)
//     q    fetch_queue_if.slave handshake bundle (see fetch_queue_if.sv)
//   Every output is decoded from registered state only; there is no
//   combinational path from any input to any output.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave q
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [PTR_W-1:0]   wr_ptr_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

  // Readiness depends only on occupancy, so a push while full is refused
  // even if decode pops in the same cycle; fetch retries next cycle.
  assign push = q.if_valid_i && !full && !q.flush_i;
  assign pop  = q.id_ready_i && !empty && !q.flush_i;

  // Pointer and occupancy next-state. DEPTH is a power of two, so the
  // pointers wrap for free at their natural width.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    cnt_nxt    = cnt;

    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Storage has no reset: stale contents are never visible because the
  // head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {q.if_pc_i, q.if_inst_i};
    end
  end

  assign head = mem[rd_ptr];

  assign q.if_ready_o = !full;
  assign q.id_valid_o = !empty;
  assign q.id_pc_o    = empty ? '0 : head[ENTRY_W-1 -: ADDR_WIDTH];
  assign q.id_inst_o  = empty ? '0 : head[INST_WIDTH-1:0];
  assign q.count_o    = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) q_if ();

  fetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set after return are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    q_if.flush_i    = 1'b0;
    q_if.if_valid_i = 1'b0;
    q_if.if_pc_i    = '0;
    q_if.if_inst_i  = '0;
    q_if.id_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", q_if.count_o); end
    checks++; if (q_if.if_ready_o !== 1'b1) begin failures++; $display("FAIL reset_if_ready: got %b want 1", q_if.if_ready_o); end
    checks++; if (q_if.id_valid_o !== 1'b0) begin failures++; $display("FAIL reset_id_valid: got %b want 0", q_if.id_valid_o); end
    checks++; if (q_if.id_pc_o !== 32'h0) begin failures++; $display("FAIL reset_id_pc: got %h want 0", q_if.id_pc_o); end
    checks++; if (q_if.id_inst_o !== 32'h0) begin failures++; $display("FAIL reset_id_inst: got %h want 0", q_if.id_inst_o); end

    // Reset in the middle of filling.
    q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h1000; q_if.if_inst_i = 32'h0000_0013;
    step();
    checks++; if (q_if.id_pc_o !== 32'h1000) begin failures++; $display("FAIL midfill_head_pc: got %h want 1000", q_if.id_pc_o); end
    q_if.if_pc_i = 32'h1004; q_if.if_inst_i = 32'h0010_0093;
    step();
    checks++; if (q_if.count_o !== 3'd2) begin failures++; $display("FAIL midfill_count: got %0d want 2", q_if.count_o); end
    q_if.if_valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL midreset_count: got %0d want 0", q_if.count_o); end
    checks++; if (q_if.id_valid_o !== 1'b0) begin failures++; $display("FAIL midreset_id_valid: got %b want 0", q_if.id_valid_o); end
    checks++; if (q_if.id_pc_o !== 32'h0) begin failures++; $display("FAIL midreset_id_pc: got %h want 0", q_if.id_pc_o); end
    checks++; if (q_if.id_inst_o !== 32'h0) begin failures++; $display("FAIL midreset_id_inst: got %h want 0", q_if.id_inst_o); end
    checks++; if (q_if.if_ready_o !== 1'b1) begin failures++; $display("FAIL midreset_if_ready: got %b want 1", q_if.if_ready_o); end
  endtask

  task automatic test_fill();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    q_if.id_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_if.if_valid_i = 1'b1;
      q_if.if_pc_i    = pcs[i];
      q_if.if_inst_i  = 32'hA000_0000 | pcs[i];
      step();
    end
    checks++; if (q_if.count_o !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", q_if.count_o); end
    checks++; if (q_if.if_ready_o !== 1'b0) begin failures++; $display("FAIL full_if_ready: got %b want 0", q_if.if_ready_o); end

    // Fifth push is held while full and must not be taken.
    q_if.if_pc_i   = 32'h10;
    q_if.if_inst_i = 32'hA000_0010;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (q_if.count_o !== 3'd4) begin failures++; $display("FAIL held_count[%0d]: got %0d want 4", i, q_if.count_o); end
      checks++; if (q_if.id_pc_o !== 32'h0) begin failures++; $display("FAIL held_head_pc[%0d]: got %h want 0", i, q_if.id_pc_o); end
    end
    checks++; if (q_if.id_inst_o !== 32'hA000_0000) begin failures++; $display("FAIL held_head_inst: got %h want a0000000", q_if.id_inst_o); end
  endtask

  // Continues from the full state left by test_fill, 0x10 still presented.
  task automatic test_wrap_drain();
    logic [31:0] exp_pc [6];
    logic [2:0]  exp_cnt [6];
    exp_pc[0] = 32'h0;  exp_pc[1] = 32'h4;  exp_pc[2] = 32'h8;
    exp_pc[3] = 32'hC;  exp_pc[4] = 32'h10; exp_pc[5] = 32'h14;
    exp_cnt[0] = 3'd4; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd3;
    exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd2; exp_cnt[5] = 3'd1;

    q_if.id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (q_if.id_pc_o !== exp_pc[i]) begin failures++; $display("FAIL drain_pc[%0d]: got %h want %h", i, q_if.id_pc_o, exp_pc[i]); end
      checks++; if (q_if.id_inst_o !== (32'hA000_0000 | exp_pc[i])) begin failures++; $display("FAIL drain_inst[%0d]: got %h want %h", i, q_if.id_inst_o, 32'hA000_0000 | exp_pc[i]); end
      checks++; if (q_if.count_o !== exp_cnt[i]) begin failures++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, q_if.count_o, exp_cnt[i]); end
      case (i)
        0: begin q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h10; q_if.if_inst_i = 32'hA000_0010; end
        1: begin q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h10; q_if.if_inst_i = 32'hA000_0010; end
        2: begin q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h14; q_if.if_inst_i = 32'hA000_0014; end
        default: q_if.if_valid_i = 1'b0;
      endcase
      step();
    end
    checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL drain_final_count: got %0d want 0", q_if.count_o); end
    checks++; if (q_if.id_valid_o !== 1'b0) begin failures++; $display("FAIL drain_final_valid: got %b want 0", q_if.id_valid_o); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    q_if.id_ready_i = 1'b0;
    q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h100; q_if.if_inst_i = 32'hB100;
    step();
    q_if.if_pc_i = 32'h104; q_if.if_inst_i = 32'hB104;
    step();
    checks++; if (q_if.count_o !== 3'd2) begin failures++; $display("FAIL pp_pre_count: got %0d want 2", q_if.count_o); end
    q_if.if_pc_i = 32'h108; q_if.if_inst_i = 32'hB108;
    q_if.id_ready_i = 1'b1;
    step();
    checks++; if (q_if.count_o !== 3'd2) begin failures++; $display("FAIL pp_count: got %0d want 2", q_if.count_o); end
    checks++; if (q_if.id_pc_o !== 32'h104) begin failures++; $display("FAIL pp_head_pc: got %h want 104", q_if.id_pc_o); end
    q_if.if_valid_i = 1'b0;
    step();
    checks++; if (q_if.id_pc_o !== 32'h108) begin failures++; $display("FAIL pp_tail_pc: got %h want 108", q_if.id_pc_o); end
    checks++; if (q_if.id_inst_o !== 32'hB108) begin failures++; $display("FAIL pp_tail_inst: got %h want b108", q_if.id_inst_o); end
    checks++; if (q_if.count_o !== 3'd1) begin failures++; $display("FAIL pp_tail_count: got %0d want 1", q_if.count_o); end
    step();
    checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL pp_end_count: got %0d want 0", q_if.count_o); end
    idle_inputs();
  endtask

  task automatic test_flush();
    q_if.id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q_if.if_valid_i = 1'b1;
      q_if.if_pc_i    = 32'h200 + 32'(4 * i);
      q_if.if_inst_i  = 32'hC200 + 32'(4 * i);
      step();
    end
    checks++; if (q_if.count_o !== 3'd3) begin failures++; $display("FAIL fl_pre_count: got %0d want 3", q_if.count_o); end
    q_if.flush_i = 1'b1;
    q_if.if_pc_i = 32'h20C; q_if.if_inst_i = 32'hC20C;
    q_if.id_ready_i = 1'b1;
    step();
    checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL fl_count: got %0d want 0", q_if.count_o); end
    checks++; if (q_if.id_valid_o !== 1'b0) begin failures++; $display("FAIL fl_valid: got %b want 0", q_if.id_valid_o); end
    checks++; if (q_if.id_inst_o !== 32'h0) begin failures++; $display("FAIL fl_inst: got %h want 0", q_if.id_inst_o); end
    checks++; if (q_if.id_pc_o !== 32'h0) begin failures++; $display("FAIL fl_pc: got %h want 0", q_if.id_pc_o); end
    q_if.flush_i = 1'b0;
    q_if.id_ready_i = 1'b0;
    q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h2000; q_if.if_inst_i = 32'h0000_0013;
    step();
    q_if.if_valid_i = 1'b0;
    checks++; if (q_if.id_pc_o !== 32'h2000) begin failures++; $display("FAIL fl_post_pc: got %h want 2000", q_if.id_pc_o); end
    checks++; if (q_if.id_inst_o !== 32'h13) begin failures++; $display("FAIL fl_post_inst: got %h want 13", q_if.id_inst_o); end
    checks++; if (q_if.count_o !== 3'd1) begin failures++; $display("FAIL fl_post_count: got %0d want 1", q_if.count_o); end
    q_if.id_ready_i = 1'b1;
    step();
    checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL fl_end_count: got %0d want 0", q_if.count_o); end
    idle_inputs();
  endtask

  task automatic test_empty_pop();
    q_if.id_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q_if.id_valid_o !== 1'b0) begin failures++; $display("FAIL ep_valid[%0d]: got %b want 0", i, q_if.id_valid_o); end
      checks++; if (q_if.count_o !== 3'd0) begin failures++; $display("FAIL ep_count[%0d]: got %0d want 0", i, q_if.count_o); end
      checks++; if (q_if.id_pc_o !== 32'h0 || q_if.id_inst_o !== 32'h0) begin failures++; $display("FAIL ep_data[%0d]: got %h/%h want 0/0", i, q_if.id_pc_o, q_if.id_inst_o); end
    end
    // Queue must still work normally after the attempted underflow.
    q_if.id_ready_i = 1'b0;
    q_if.if_valid_i = 1'b1; q_if.if_pc_i = 32'h300; q_if.if_inst_i = 32'hD300;
    step();
    q_if.if_valid_i = 1'b0;
    checks++; if (q_if.count_o !== 3'd1) begin failures++; $display("FAIL ep_recover_count: got %0d want 1", q_if.count_o); end
    checks++; if (q_if.id_pc_o !== 32'h300) begin failures++; $display("FAIL ep_recover_pc: got %h want 300", q_if.id_pc_o); end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    test_reset();
    test_fill();
    test_wrap_drain();
    test_back_to_back();
    test_flush();
    test_empty_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
